tpm_tis_regs: RTL and testbench
===============================

// Module: tpm_tis_regs
// PURPOSE
//  TPM TIS-style register file directly downstream of LPCPeripheral: consumes its addr/outData/didWrite/didRead.
//  Supplies read data back to LPCPeripheral.inData.
//  Buffers host command bytes in a FIFO and hands them to the TPM core as a byte stream.
//  Buffers response bytes from the core for host read-out. Runs the TIS command state machine.
// PARAMETERS
//  BASE_ADDR  16'h0000  I/O base; register offsets below are added to it
//  CMD_DEPTH  64        command FIFO depth in bytes, power of 2
//  RSP_DEPTH  64        response FIFO depth in bytes, power of 2
//  VID_DID    32'h0001_1D1D  value returned at offsets 0xF00..0xF03, little-endian
// PORTS
//  clk        in   1   system clock
//  reset      in   1   asynchronous, active-low reset
//  addr       in   16  I/O address from LPCPeripheral, stable for the whole cycle
//  wrData     in   8   write data (LPCPeripheral.outData)
//  didWrite   in   1   1-clk pulse: write at addr completed
//  didRead    in   1   1-clk pulse: read at addr completed; fires the pop side effect
//  rdData     out  8   read data (to LPCPeripheral.inData); combinational from addr and state
//  cmdData    out  8   command byte to core
//  cmdValid   out  1   command byte valid; only in EXECUTION
//  cmdReady   in   1   core accepts byte
//  execStart  out  1   1-clk pulse on entry to EXECUTION
//  rspData    in   8   response byte from core
//  rspValid   in   1   response byte valid
//  rspReady   out  1   = (state==EXECUTION) && !rspFull
//  rspDone    in   1   1-clk pulse: response complete
//  irq        out  1   interrupt; present only with TPM_TIS_INT_EN
// BEHAVIOUR
//  Registers, by offset:
//   0x018 STS: [7] stsValid=1, [6] commandReady, [5] tpmGo (W only, reads 0), [4] dataAvail, [3] expect; other bits 0.
//   0x019/0x01A burstCount lo/hi; read only.
//   0x024 DATA_FIFO.
//   0xF00-0xF03 VID_DID.
//   Unmapped reads return 8'hFF; unmapped writes are ignored.
//  States: IDLE, READY, RECEPTION, EXECUTION, COMPLETION. Reset enters IDLE and empties both FIFOs.
//  Reset values: cmdValid=0, execStart=0, rspReady=0, irq=0.
//  Transitions:
//   - Write STS[6]=1 in IDLE, RECEPTION or COMPLETION -> READY; flush both FIFOs.
//   - Write STS[6]=1 in READY or EXECUTION is ignored.
//   - READY: DATA_FIFO write pushes the byte and moves to RECEPTION.
//   - RECEPTION: DATA_FIFO write pushes while expect=1. Write with expect=0 or FIFO full is dropped.
//   - RECEPTION: write STS[5]=1 with expect=0 -> EXECUTION next clk and pulses execStart. With expect=1 it is ignored.
//   - EXECUTION: rspDone -> COMPLETION, including when the rsp FIFO is empty.
//  Writes to DATA_FIFO in IDLE, EXECUTION or COMPLETION are dropped.
//  expect = RECEPTION && (cnt<6 || cnt<paramSize).
//   - paramSize = command bytes 2..5 (byte offsets), big-endian 32-bit, latched as bytes arrive.
//   - cnt saturates at CMD_DEPTH.
//  commandReady = (state==READY). dataAvail = COMPLETION && rsp FIFO non-empty.
//  burstCount:
//   - CMD_DEPTH-cnt in READY/RECEPTION.
//   - rsp occupancy in COMPLETION.
//   - 0 otherwise.
//   - 16-bit, zero-extended.
//  DATA_FIFO read: rdData = rsp head in COMPLETION, else 8'hFF.
//   - didRead at DATA_FIFO pops only if COMPLETION and non-empty.
//   - Pop on empty leaves state unchanged.
//  Core side: the cmd FIFO drains at 1 byte/clk while cmdValid&&cmdReady. The rsp FIFO pushes on rspValid&&rspReady.
//  Host push/core pop and core push/host pop never coincide: the state machine separates them.
//  didWrite and didRead in the same clk: the write is processed and the read side effect dropped.
//  Reset asserted mid-command aborts immediately; no execStart is issued afterwards.
// CONFIGURATION
//  TPM_TIS_INT_EN defined:
//   - 0x008 INT_ENABLE: [7] globalEn, [0] dataAvailEn, [2] commandReadyEn.
//   - 0x010 INT_STATUS: same bit positions, write-1-to-clear.
//   - A status bit sets on the rising edge of dataAvail or commandReady.
//   - irq = globalEn && |(INT_STATUS & INT_ENABLE); registered, 0 at reset.
//  TPM_TIS_INT_EN undefined:
//   - 0x008/0x010 read 8'h00; writes are ignored.
//   - irq is tied 0 and the port is omitted.
// STRUCTURE
//  tpm_tis_pkg: state enum tis_state_t, register offset localparams, STS bit indices, read-default 8'hFF.
//  Sub-module tpm_byte_fifo (push, pop, flush, dout, count, full, empty; parameter DEPTH).
//  Instantiated twice: command FIFO and response FIFO.
// TESTING
//  1 Reset, read 0x018 -> 8'h80; read 0xF00 -> 8'h1D; read 0x123 -> 8'hFF.
//  2 Write 0x018=8'h40 -> READY; read 0x018 -> 8'hC0; burstCount reads 0x40/0x00.
//  3 Push 80 01 00 00 00 0A 00 00 01 44 to DATA_FIFO:
//    - expect reads 1 after byte 9 and 0 after byte 10.
//    - An 11th write is dropped.
//    - Write STS=8'h20 -> execStart pulses once; core receives exactly 10 bytes in order.
//  4 Core pushes AA BB then pulses rspDone:
//    - STS reads 8'h90; burstCount reads 2.
//    - DATA_FIFO reads return AA then BB.
//    - STS then reads 8'h80; a 3rd read returns 8'hFF with no state change.
//  5 STS=8'h20 written while expect=1 -> stays RECEPTION; STS=8'h40 -> READY with the FIFO flushed.
//  6 With TPM_TIS_INT_EN: INT_ENABLE=8'h81, run scenario 4 -> irq rises; writing INT_STATUS=8'h01 -> irq falls next clk.

Source files
------------

// File: rtl/tpm_tis_pkg.sv
// Shared types and constants for the TIS register block: FSM states, register
// offsets and bit positions inside STS and the interrupt registers.
package tpm_tis_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READY,
    RECEPTION,
    EXECUTION,
    COMPLETION
  } tis_state_t;

  localparam logic [15:0] OFF_INT_ENABLE = 16'h0008;
  localparam logic [15:0] OFF_INT_STATUS = 16'h0010;
  localparam logic [15:0] OFF_STS        = 16'h0018;
  localparam logic [15:0] OFF_BURST_LO   = 16'h0019;
  localparam logic [15:0] OFF_BURST_HI   = 16'h001A;
  localparam logic [15:0] OFF_DATA_FIFO  = 16'h0024;
  localparam logic [15:0] OFF_VID_DID    = 16'h0F00;

  localparam int STS_VALID      = 7;
  localparam int STS_CMD_READY  = 6;
  localparam int STS_GO         = 5;
  localparam int STS_DATA_AVAIL = 4;
  localparam int STS_EXPECT     = 3;

  localparam int INT_GLOBAL     = 7;
  localparam int INT_CMD_READY  = 2;
  localparam int INT_DATA_AVAIL = 0;

  localparam logic [7:0] RD_DEFAULT = 8'hFF;

endpackage

// File: rtl/tpm_byte_fifo.sv
// Byte FIFO with synchronous flush. The head is read combinationally so the
// host read path can return it in the same cycle as the address.
module tpm_byte_fifo #(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic          doPush;
  logic          doPop;

  assign full   = (count == CNT_FULL);
  assign empty  = (count == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign dout   = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_ONE;
      if (doPop)  rdPtr <= rdPtr + PTR_ONE;
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/tpm_tis_regs.sv
// TIS register file behind the LPC peripheral: command/response FIFOs and the
// TIS command FSM. Define TPM_TIS_INT_EN to add INT_ENABLE/INT_STATUS and irq.
module tpm_tis_regs
  import tpm_tis_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          CMD_DEPTH = 64,
  parameter int          RSP_DEPTH = 64,
  parameter logic [31:0] VID_DID   = 32'h0001_1D1D
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [7:0]  wrData,
  input  logic        didWrite,
  input  logic        didRead,
  output logic [7:0]  rdData,
  output logic [7:0]  cmdData,
  output logic        cmdValid,
  input  logic        cmdReady,
  output logic        execStart,
  input  logic [7:0]  rspData,
  input  logic        rspValid,
  output logic        rspReady,
  input  logic        rspDone
`ifdef TPM_TIS_INT_EN
  ,
  output logic        irq
`endif
);

  localparam int CW = $clog2(CMD_DEPTH) + 1;
  localparam int RW = $clog2(RSP_DEPTH) + 1;

  tis_state_t    state;
  logic [15:0]   offset;
  logic [CW-1:0] cmdCount;
  logic [RW-1:0] rspCount;
  logic          cmdFull, cmdEmpty, rspFull, rspEmpty;
  logic [7:0]    rspHead;
  logic [31:0]   paramSize;
  logic [15:0]   burstCount;
  logic          wrSts, wrFifo, rdFifo;
  logic          expectBit, commandReady, dataAvail;
  logic          readyReq, goAccept, cmdPush, cmdPop, rspPush, rspPop;

  assign offset       = addr - BASE_ADDR;
  assign wrSts        = didWrite && (offset == OFF_STS);
  assign wrFifo       = didWrite && (offset == OFF_DATA_FIFO);
  // A write in the same cycle suppresses the read's pop side effect.
  assign rdFifo       = didRead && !didWrite && (offset == OFF_DATA_FIFO);

  // The command FIFO only drains in EXECUTION, so its occupancy doubles as the
  // received-byte count while the host is still filling it.
  assign expectBit    = (state == RECEPTION) &&
                        ((32'(cmdCount) < 32'd6) || (32'(cmdCount) < paramSize));
  assign commandReady = (state == READY);
  assign dataAvail    = (state == COMPLETION) && !rspEmpty;

  assign readyReq = wrSts && wrData[STS_CMD_READY] &&
                    ((state == IDLE) || (state == RECEPTION) || (state == COMPLETION));
  assign goAccept = wrSts && wrData[STS_GO] && (state == RECEPTION) && !expectBit;
  assign cmdPush  = wrFifo && !cmdFull && ((state == READY) || expectBit);
  assign cmdValid = (state == EXECUTION) && !cmdEmpty;
  assign cmdPop   = cmdValid && cmdReady;
  assign rspReady = (state == EXECUTION) && !rspFull;
  assign rspPush  = rspValid && rspReady;
  assign rspPop   = rdFifo && dataAvail;

  tpm_byte_fifo #(.DEPTH(CMD_DEPTH)) cmdFifo (
    .clk(clk), .reset(reset), .push(cmdPush), .pop(cmdPop), .flush(readyReq),
    .din(wrData), .dout(cmdData), .count(cmdCount), .full(cmdFull), .empty(cmdEmpty)
  );

  tpm_byte_fifo #(.DEPTH(RSP_DEPTH)) rspFifo (
    .clk(clk), .reset(reset), .push(rspPush), .pop(rspPop), .flush(readyReq),
    .din(rspData), .dout(rspHead), .count(rspCount), .full(rspFull), .empty(rspEmpty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      paramSize <= '0;
      execStart <= 1'b0;
    end else begin
      execStart <= 1'b0;
      if (readyReq) begin
        state     <= READY;
        paramSize <= '0;
      end else begin
        case (state)
          READY, RECEPTION: begin
            if (cmdPush) begin
              state <= RECEPTION;
              case (cmdCount)
                CW'(2):  paramSize[31:24] <= wrData;
                CW'(3):  paramSize[23:16] <= wrData;
                CW'(4):  paramSize[15:8]  <= wrData;
                CW'(5):  paramSize[7:0]   <= wrData;
                default: ;
              endcase
            end else if (goAccept) begin
              state     <= EXECUTION;
              execStart <= 1'b1;
            end
          end
          EXECUTION: if (rspDone) state <= COMPLETION;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    burstCount = 16'h0000;
    case (state)
      READY, RECEPTION: burstCount = 16'(CMD_DEPTH) - 16'(cmdCount);
      COMPLETION:       burstCount = 16'(rspCount);
      default: ;
    endcase
  end

`ifdef TPM_TIS_INT_EN
  localparam logic [7:0] EN_MASK  = 8'h85;
  localparam logic [7:0] SRC_MASK = 8'h05;

  logic [7:0] intEnable, intEnableNext;
  logic [7:0] intStatus, intStatusNext;
  logic       dataAvailPrev, commandReadyPrev;

  always_comb begin
    intEnableNext = intEnable;
    intStatusNext = intStatus;
    if (didWrite && (offset == OFF_INT_ENABLE)) intEnableNext = wrData & EN_MASK;
    if (didWrite && (offset == OFF_INT_STATUS)) intStatusNext = intStatus & ~wrData;
    if (dataAvail && !dataAvailPrev)         intStatusNext[INT_DATA_AVAIL] = 1'b1;
    if (commandReady && !commandReadyPrev)   intStatusNext[INT_CMD_READY]  = 1'b1;
  end

  // irq follows the next-state values so a clear takes effect on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      intEnable        <= '0;
      intStatus        <= '0;
      dataAvailPrev    <= 1'b0;
      commandReadyPrev <= 1'b0;
      irq              <= 1'b0;
    end else begin
      intEnable        <= intEnableNext;
      intStatus        <= intStatusNext;
      dataAvailPrev    <= dataAvail;
      commandReadyPrev <= commandReady;
      irq              <= intEnableNext[INT_GLOBAL] && |(intStatusNext & intEnableNext & SRC_MASK);
    end
  end
`endif

  always_comb begin
    rdData = RD_DEFAULT;
    case (offset)
      OFF_STS: begin
        rdData                 = 8'h00;
        rdData[STS_VALID]      = 1'b1;
        rdData[STS_CMD_READY]  = commandReady;
        rdData[STS_DATA_AVAIL] = dataAvail;
        rdData[STS_EXPECT]     = expectBit;
      end
      OFF_BURST_LO:          rdData = burstCount[7:0];
      OFF_BURST_HI:          rdData = burstCount[15:8];
      OFF_DATA_FIFO:         rdData = dataAvail ? rspHead : RD_DEFAULT;
      OFF_VID_DID:           rdData = VID_DID[7:0];
      OFF_VID_DID + 16'd1:   rdData = VID_DID[15:8];
      OFF_VID_DID + 16'd2:   rdData = VID_DID[23:16];
      OFF_VID_DID + 16'd3:   rdData = VID_DID[31:24];
`ifdef TPM_TIS_INT_EN
      OFF_INT_ENABLE:        rdData = intEnable;
      OFF_INT_STATUS:        rdData = intStatus;
`else
      OFF_INT_ENABLE:        rdData = 8'h00;
      OFF_INT_STATUS:        rdData = 8'h00;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tpm_tis_regs.sv
// Scenario bench for tpm_tis_regs: expected bytes are queued as stimulus is
// driven and compared as the register file or core interface returns them.
module tb_tpm_tis_regs;

  localparam logic [15:0] STS   = 16'h0018;
  localparam logic [15:0] BLO   = 16'h0019;
  localparam logic [15:0] BHI   = 16'h001A;
  localparam logic [15:0] DFIFO = 16'h0024;
  localparam logic [15:0] INTEN = 16'h0008;
  localparam logic [15:0] INTST = 16'h0010;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  wrData = 8'h00;
  logic        didWrite = 1'b0;
  logic        didRead = 1'b0;
  logic [7:0]  rdData;
  logic [7:0]  cmdData;
  logic        cmdValid;
  logic        cmdReady = 1'b0;
  logic        execStart;
  logic [7:0]  rspData = 8'h00;
  logic        rspValid = 1'b0;
  logic        rspReady;
  logic        rspDone = 1'b0;
`ifdef TPM_TIS_INT_EN
  logic        irq;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] expQ[$];
  logic [7:0] gotQ[$];
  string      nameQ[$];

  always #5 clk = ~clk;

  tpm_tis_regs dut (
    .clk(clk), .reset(reset), .addr(addr), .wrData(wrData),
    .didWrite(didWrite), .didRead(didRead), .rdData(rdData),
    .cmdData(cmdData), .cmdValid(cmdValid), .cmdReady(cmdReady),
    .execStart(execStart), .rspData(rspData), .rspValid(rspValid),
    .rspReady(rspReady), .rspDone(rspDone)
`ifdef TPM_TIS_INT_EN
    , .irq(irq)
`endif
  );

  task automatic hostWrite(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; wrData = d; didWrite = 1'b1;
    @(negedge clk);
    didWrite = 1'b0;
  endtask

  task automatic readExpect(input string n, input logic [15:0] a, input logic [7:0] e);
    @(negedge clk);
    addr = a;
    nameQ.push_back(n);
    expQ.push_back(e);
    #1;
    gotQ.push_back(rdData);
    didRead = 1'b1;
    @(negedge clk);
    didRead = 1'b0;
  endtask

  task automatic sendCmd6();
    logic [7:0] b [6] = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h06};
    for (int i = 0; i < 6; i++) hostWrite(DFIFO, b[i]);
    cmdReady = 1'b1;
    hostWrite(STS, 8'h20);
    repeat (10) @(negedge clk);
    cmdReady = 1'b0;
  endtask

  task automatic respond(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk); rspData = a; rspValid = 1'b1;
    @(negedge clk); rspData = b;
    @(negedge clk); rspValid = 1'b0; rspDone = 1'b1;
    @(negedge clk); rspDone = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] e, g;
    string n;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({cmdValid, execStart, rspReady} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b required 000", {cmdValid, execStart, rspReady});
    end
`ifdef TPM_TIS_INT_EN
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_irq: got %b required 0", irq);
    end
`endif
    reset = 1'b1;
    readExpect("reset_sts", STS, 8'h80);
    readExpect("vid_f00", 16'h0F00, 8'h1D);
    readExpect("vid_f01", 16'h0F01, 8'h1D);
    readExpect("vid_f02", 16'h0F02, 8'h01);
    readExpect("vid_f03", 16'h0F03, 8'h00);
    readExpect("unmapped", 16'h0123, 8'hFF);
    readExpect("int_enable_reset", INTEN, 8'h00);
    readExpect("int_status_reset", INTST, 8'h00);
    hostWrite(16'h0123, 8'h55);
    readExpect("unmapped_after_wr", 16'h0123, 8'hFF);
    hostWrite(DFIFO, 8'h77);
    readExpect("idle_burst_lo", BLO, 8'h00);
    readExpect("idle_data_fifo", DFIFO, 8'hFF);
    readExpect("idle_sts", STS, 8'h80);
    while (expQ.size() != 0) begin
      e = expQ.pop_front(); g = gotQ.pop_front(); n = nameQ.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL %s: got %02h required %02h", n, g, e);
      end
    end
  endtask

  task automatic test_ready();
    logic [7:0] e, g;
    string n;
    hostWrite(STS, 8'h40);
    readExpect("ready_sts", STS, 8'hC0);
    readExpect("ready_burst_lo", BLO, 8'h40);
    readExpect("ready_burst_hi", BHI, 8'h00);
    while (expQ.size() != 0) begin
      e = expQ.pop_front(); g = gotQ.pop_front(); n = nameQ.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL %s: got %02h required %02h", n, g, e);
      end
    end
  endtask

  task automatic test_command();
    logic [7:0] bytes [10] = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h01, 8'h44};
    logic [7:0] cmdQ[$];
    logic [7:0] gotCmd[$];
    logic [7:0] e, g;
    string n;
    int starts = 0;
    for (int i = 0; i < 10; i++) begin
      hostWrite(DFIFO, bytes[i]);
      cmdQ.push_back(bytes[i]);
      if (i == 0) readExpect("sts_after_byte1", STS, 8'h88);
      if (i == 8) readExpect("sts_after_byte9", STS, 8'h88);
      if (i == 9) readExpect("sts_after_byte10", STS, 8'h80);
    end
    readExpect("burst_after_10", BLO, 8'h36);
    hostWrite(DFIFO, 8'h55);
    readExpect("burst_after_11th", BLO, 8'h36);
    readExpect("sts_after_11th", STS, 8'h80);
    while (expQ.size() != 0) begin
      e = expQ.pop_front(); g = gotQ.pop_front(); n = nameQ.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL %s: got %02h required %02h", n, g, e);
      end
    end
    cmdReady = 1'b1;
    @(negedge clk);
    vectors++;
    if (cmdValid !== 1'b0) begin
      miscompares++;
      $display("FAIL cmdvalid_before_go: got %b required 0", cmdValid);
    end
    hostWrite(STS, 8'h20);
    for (int k = 0; k < 30; k++) begin
      if (execStart === 1'b1) starts++;
      if (cmdValid === 1'b1 && cmdReady) gotCmd.push_back(cmdData);
      @(negedge clk);
    end
    cmdReady = 1'b0;
    vectors++;
    if (starts != 1) begin
      miscompares++;
      $display("FAIL exec_start_pulses: got %0d required 1", starts);
    end
    vectors++;
    if (gotCmd.size() != cmdQ.size()) begin
      miscompares++;
      $display("FAIL cmd_byte_count: got %0d required %0d", gotCmd.size(), cmdQ.size());
    end
    for (int i = 0; cmdQ.size() != 0; i++) begin
      e = cmdQ.pop_front();
      g = (gotCmd.size() != 0) ? gotCmd.pop_front() : 8'hxx;
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL cmd_byte_%0d: got %02h required %02h", i, g, e);
      end
    end
  endtask

  task automatic test_response();
    logic [7:0] e, g;
    string n;
    @(negedge clk);
    vectors++;
    if (rspReady !== 1'b1) begin
      miscompares++;
      $display("FAIL rspready_exec: got %b required 1", rspReady);
    end
    respond(8'hAA, 8'hBB);
    vectors++;
    if (rspReady !== 1'b0) begin
      miscompares++;
      $display("FAIL rspready_completion: got %b required 0", rspReady);
    end
    readExpect("completion_sts", STS, 8'h90);
    readExpect("completion_burst_lo", BLO, 8'h02);
    readExpect("completion_burst_hi", BHI, 8'h00);
    readExpect("rsp_byte0", DFIFO, 8'hAA);
    readExpect("rsp_byte1", DFIFO, 8'hBB);
    readExpect("drained_sts", STS, 8'h80);
    readExpect("drained_burst_lo", BLO, 8'h00);
    readExpect("read_empty", DFIFO, 8'hFF);
    readExpect("sts_after_empty_read", STS, 8'h80);
    while (expQ.size() != 0) begin
      e = expQ.pop_front(); g = gotQ.pop_front(); n = nameQ.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL %s: got %02h required %02h", n, g, e);
      end
    end
  endtask

  task automatic test_expect_guard();
    logic [7:0] e, g;
    string n;
    hostWrite(STS, 8'h40);
    readExpect("cmpl_to_ready_sts", STS, 8'hC0);
    hostWrite(DFIFO, 8'h80);
    hostWrite(DFIFO, 8'h01);
    hostWrite(DFIFO, 8'h00);
    readExpect("partial_sts", STS, 8'h88);
    readExpect("partial_burst_lo", BLO, 8'h3D);
    hostWrite(STS, 8'h20);
    vectors++;
    if (execStart !== 1'b0) begin
      miscompares++;
      $display("FAIL early_go_execstart: got %b required 0", execStart);
    end
    readExpect("early_go_sts", STS, 8'h88);
    hostWrite(STS, 8'h40);
    readExpect("abort_ready_sts", STS, 8'hC0);
    readExpect("abort_flushed_burst", BLO, 8'h40);
    while (expQ.size() != 0) begin
      e = expQ.pop_front(); g = gotQ.pop_front(); n = nameQ.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL %s: got %02h required %02h", n, g, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e, g;
    string n;
    sendCmd6();
    respond(8'h11, 8'h22);
    readExpect("b2b_sts", STS, 8'h90);
    @(negedge clk);
    addr = DFIFO; wrData = 8'h99; didWrite = 1'b1; didRead = 1'b1;
    @(negedge clk);
    didWrite = 1'b0; didRead = 1'b0;
    readExpect("b2b_head_kept", DFIFO, 8'h11);
    readExpect("b2b_second", DFIFO, 8'h22);
    readExpect("b2b_empty_sts", STS, 8'h80);
    while (expQ.size() != 0) begin
      e = expQ.pop_front(); g = gotQ.pop_front(); n = nameQ.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL %s: got %02h required %02h", n, g, e);
      end
    end
  endtask

`ifdef TPM_TIS_INT_EN
  task automatic test_interrupt();
    logic [7:0] e, g;
    string n;
    hostWrite(INTEN, 8'h81);
    hostWrite(INTST, 8'hFF);
    readExpect("int_enable_rb", INTEN, 8'h81);
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_idle: got %b required 0", irq);
    end
    hostWrite(STS, 8'h40);
    sendCmd6();
    respond(8'hAA, 8'hBB);
    repeat (2) @(negedge clk);
    vectors++;
    if (irq !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_data_avail: got %b required 1", irq);
    end
    readExpect("int_status_set", INTST, 8'h05);
    hostWrite(INTST, 8'h01);
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_cleared: got %b required 0", irq);
    end
    readExpect("int_status_cleared", INTST, 8'h04);
    while (expQ.size() != 0) begin
      e = expQ.pop_front(); g = gotQ.pop_front(); n = nameQ.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL %s: got %02h required %02h", n, g, e);
      end
    end
  endtask
`endif

  task automatic test_reset_abort();
    logic [7:0] e, g;
    string n;
    int starts = 0;
    int valids = 0;
    hostWrite(STS, 8'h40);
    hostWrite(DFIFO, 8'h80);
    hostWrite(DFIFO, 8'h01);
    hostWrite(DFIFO, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    readExpect("abort_sts", STS, 8'h80);
    readExpect("abort_burst_lo", BLO, 8'h00);
    cmdReady = 1'b1;
    hostWrite(STS, 8'h20);
    for (int k = 0; k < 8; k++) begin
      if (execStart === 1'b1) starts++;
      if (cmdValid === 1'b1) valids++;
      @(negedge clk);
    end
    cmdReady = 1'b0;
    vectors++;
    if (starts != 0 || valids != 0) begin
      miscompares++;
      $display("FAIL abort_no_exec: got starts=%0d valids=%0d required 0/0", starts, valids);
    end
    readExpect("abort_final_sts", STS, 8'h80);
    while (expQ.size() != 0) begin
      e = expQ.pop_front(); g = gotQ.pop_front(); n = nameQ.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL %s: got %02h required %02h", n, g, e);
      end
    end
  endtask

  initial begin
    #500000;
    miscompares++;
    $display("FAIL watchdog: got timeout required finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "bench timed out");
  end

  initial begin
    test_reset();
    test_ready();
    test_command();
    test_response();
    test_expect_guard();
    test_back_to_back();
`ifdef TPM_TIS_INT_EN
    test_interrupt();
`endif
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
